// File: rtl/pipemem_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
package pipemem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned TMO_DEFAULT = 255;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

endpackage

// File: rtl/pipememtmr.sv
// Saturating 16-bit timeout counter; expired flags the BUSY cycle whose closing edge reaches lim.
module pipememtmr (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        run,
  input  logic [15:0] lim,
  output logic        expired
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr || start) begin
      r_cnt <= 16'd0;
    end else if (run && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // r_cnt counts completed BUSY cycles, so this edge brings the count to r_cnt+1.
  assign expired = run && (({1'b0, r_cnt} + 17'd1) >= {1'b0, lim});

endmodule

// File: rtl/pipememarb.sv
// Fetch/data arbiter for a single-port memory: data first, one transaction at a time,
// global stall while a request is outstanding, bus-error abort on timeout.
module pipememarb
  import pipemem_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ireq,
  input  logic [31:0] ipc,
  output logic [31:0] inst,
  output logic        iready,
  input  logic        dreq,
  input  logic        dwe,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic [31:0] dmo,
  output logic        dready,
  output logic        stall,
  output logic        mreq,
  output logic        mwe,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack,
  output logic        berr,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] LIM = 16'(TMO);

  state_t r_state;
  state_t w_next;
  logic   w_busy;
  logic   w_start;
  logic   w_expired;
  logic   w_end;
  logic   w_kind;

  assign w_busy  = (r_state == ST_IBUSY) || (r_state == ST_DBUSY);
  assign w_start = (r_state == ST_IDLE) && (dreq || ireq);
  assign w_end   = w_busy && (mack || w_expired);
  assign w_kind  = (r_state == ST_DBUSY) ? REQ_DATA : REQ_FETCH;

  pipememtmr u_tmr (
    .clk     (clk),
    .clr     (clr),
    .start   (w_start),
    .run     (w_busy),
    .lim     (LIM),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (dreq) begin
          w_next = ST_DBUSY;
        end else if (ireq) begin
          w_next = ST_IBUSY;
        end
      end
      ST_IBUSY, ST_DBUSY: begin
        if (w_end) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mreq   <= 1'b0;
      mwe    <= 1'b0;
      maddr  <= 32'd0;
      mwdata <= 32'd0;
      inst   <= 32'd0;
      dmo    <= 32'd0;
      iready <= 1'b0;
      dready <= 1'b0;
      berr   <= 1'b0;
    end else begin
      mreq   <= (w_next == ST_IBUSY) || (w_next == ST_DBUSY);
      iready <= 1'b0;
      dready <= 1'b0;
      berr   <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (dreq) begin
          mwe    <= dwe;
          maddr  <= daddr;
          mwdata <= dwdata;
        end else if (ireq) begin
          mwe   <= 1'b0;
          maddr <= ipc;
        end
      end
      // An ack on the expiry edge still completes the transaction normally.
      if (w_end) begin
        berr <= ~mack;
        if (w_kind == REQ_DATA) begin
          dready <= 1'b1;
          dmo    <= (mack && !mwe) ? mrdata : 32'd0;
        end else begin
          iready <= 1'b1;
          inst   <= mack ? mrdata : 32'd0;
        end
      end
    end
  end

  assign stall     = (dreq & ~dready) | (ireq & ~iready);
  assign dbg_state = r_state;

endmodule
